// File: rtl/fir_pkg.sv
// Shared widths and the sequencer state encoding for the FIR tap sequencer.
package fir_pkg;

  localparam int SAMP_W      = 18;
  localparam int COEF_W      = 36;
  localparam int ACC_W       = 68;
  localparam int MAC_LAT_DEF = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUTPUT
  } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store: one write port, one registered read port that returns
// zero whenever no read is issued, plus a zeroing write used while initialising.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter  int NTAPS = 64,
  localparam int AW    = $clog2(NTAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              init_clr,
  input  logic [AW-1:0]     wr_addr,
  input  logic [SAMP_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [SAMP_W-1:0] rd_data
);

  logic signed [SAMP_W-1:0] mem_q [NTAPS];
  logic signed [SAMP_W-1:0] mem_d [NTAPS];
  logic signed [SAMP_W-1:0] rd_data_q;
  logic signed [SAMP_W-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = init_clr ? '0 : wr_data;
    end
    rd_data_d = rd_en ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Read register doubles as the MAC sample operand, so it must reset to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds NTAPS (sample, coefficient) pairs per accepted sample into the external
// MAC, drains its pipeline and holds the full-precision result on a valid/ready port.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter  int NTAPS   = 64,
  parameter  int MAC_LAT = MAC_LAT_DEF,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SAMP_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              mac_clear,
  output logic [SAMP_W-1:0] mac_a,
  output logic [COEF_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int             DW         = $clog2(MAC_LAT) + 1;
  localparam logic [AW-1:0]  TAP_LAST   = AW'(NTAPS - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(MAC_LAT - 1);

  state_t                   state_q, state_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            base_q, base_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic [AW-1:0]            tap_nxt;
  logic [DW-1:0]            drain_q, drain_d;
  logic signed [COEF_W-1:0] mac_b_q, mac_b_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];

  logic                     dl_we;
  logic                     dl_clr;
  logic [AW-1:0]            dl_waddr;
  logic                     dl_rd_en;
  logic [AW-1:0]            dl_raddr;
  logic                     in_ready_c;
  logic                     mac_clear_c;

  assign tap_nxt = tap_q + 1'b1;

  always_comb begin
    coef_d = coef_q;
    if (coef_we) begin
      coef_d[coef_addr] = coef_data;
    end
  end

  // The MAC accumulates every cycle, so every operand path defaults to zero
  // and only the reads issued from CLEAR/RUN produce non-zero pairs.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    tap_d       = tap_q;
    drain_d     = drain_q;
    mac_b_d     = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dl_we       = 1'b0;
    dl_clr      = 1'b0;
    dl_waddr    = wr_ptr_q;
    dl_rd_en    = 1'b0;
    dl_raddr    = base_q;
    in_ready_c  = 1'b0;
    mac_clear_c = 1'b0;

    unique case (state_q)
      INIT: begin
        mac_clear_c = 1'b1;
        dl_we       = 1'b1;
        dl_clr      = 1'b1;
        dl_waddr    = tap_q;
        tap_d       = tap_nxt;
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          dl_we    = 1'b1;
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear_c = 1'b1;
        dl_rd_en    = 1'b1;
        dl_raddr    = base_q;
        mac_b_d     = coef_q[0];
        tap_d       = '0;
        state_d     = RUN;
      end
      RUN: begin
        // tap_q is the tap on the operand registers now; fetch the next one.
        if (tap_q != TAP_LAST) begin
          dl_rd_en = 1'b1;
          dl_raddr = base_q - tap_nxt;
          mac_b_d  = coef_q[tap_nxt];
          tap_d    = tap_nxt;
        end else begin
          tap_d   = '0;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          out_data_d  = mac_out;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      tap_q       <= '0;
      drain_q     <= '0;
      mac_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      mac_b_q     <= mac_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clock) begin
    coef_q <= coef_d;
  end

  fir_delay_line #(
    .NTAPS(NTAPS)
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (dl_we),
    .init_clr(dl_clr),
    .wr_addr (dl_waddr),
    .wr_data (in_data),
    .rd_en   (dl_rd_en),
    .rd_addr (dl_raddr),
    .rd_data (mac_a)
  );

  assign in_ready  = in_ready_c;
  assign mac_clear = mac_clear_c;
  assign mac_b     = mac_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a behavioural MAC closes the loop, a direct
// convolution over the accepted-sample history supplies every expected output.
module tb_fir_tap_sequencer;

  localparam int NTAPS   = 64;
  localparam int MAC_LAT = 4;
  localparam int AW      = $clog2(NTAPS);

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [17:0]   in_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [35:0]   coef_data;
  logic          mac_clear;
  logic [17:0]   mac_a;
  logic [35:0]   mac_b;
  logic [67:0]   mac_out;
  logic          out_valid;
  logic          out_ready;
  logic [67:0]   out_data;

  int n_chk = 0;
  int n_err = 0;

  logic signed [35:0] coef_m [NTAPS];
  logic signed [17:0] hist [$];

  fir_tap_sequencer #(
    .NTAPS  (NTAPS),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .mac_clear(mac_clear),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_out  (mac_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural MAC: a pair presented in cycle P is in the accumulator at P+MAC_LAT.
  logic signed [17:0] a_s;
  logic signed [35:0] b_s;
  logic signed [67:0] a_x, b_x;
  logic signed [67:0] pp [MAC_LAT-1];
  logic               cp [MAC_LAT-1];
  logic signed [67:0] acc;

  assign a_s = mac_a;
  assign b_s = mac_b;
  assign a_x = a_s;
  assign b_x = b_s;
  assign mac_out = acc;

  always @(posedge clock) begin
    pp[0] <= a_x * b_x;
    cp[0] <= mac_clear;
    for (int i = 1; i < MAC_LAT - 1; i++) begin
      pp[i] <= pp[i-1];
      cp[i] <= cp[i-1];
    end
    acc <= cp[MAC_LAT-2] ? '0 : acc + pp[MAC_LAT-2];
  end

  task automatic chk_val(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic signed [67:0] gold();
    logic signed [67:0] s, c, x;
    int n;
    s = '0;
    n = hist.size();
    for (int k = 0; k < NTAPS; k++) begin
      if (n - 1 - k >= 0) begin
        c = coef_m[k];
        x = hist[n-1-k];
        s = s + c * x;
      end
    end
    return s;
  endfunction

  task automatic wr_coef(input int k, input logic signed [35:0] v);
    coef_we   = 1'b1;
    coef_addr = AW'(k);
    coef_data = v;
    tick();
    coef_we   = 1'b0;
    coef_m[k] = v;
  endtask

  task automatic rand_coefs();
    logic [63:0] r;
    for (int k = 0; k < NTAPS; k++) begin
      r = {$urandom(), $urandom()};
      wr_coef(k, r[35:0]);
    end
  endtask

  task automatic init_wait(input string tag);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    while (!in_ready && n < 200) begin
      if (mac_clear !== 1'b1 || mac_a !== '0 || mac_b !== '0) bad = 1'b1;
      tick();
      n++;
    end
    chk_val({tag, "_init_len"}, 68'(n), 68'd64);
    chk_val({tag, "_init_ops"}, 68'(bad), 68'd0);
    chk_val({tag, "_clear_off"}, 68'(mac_clear), 68'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) chk_val("ready_timeout", 68'(in_ready), 68'd1);
  endtask

  // Entered in the cycle after acceptance; returns one cycle after the output handshake.
  task automatic wait_out(input logic signed [67:0] e, input int bp, output logic signed [67:0] y);
    int lat;
    logic [67:0] held;
    lat = 1;
    if (bp == 0) out_ready = 1'b1;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
    chk_val("latency", 68'(lat), 68'd70);
    chk_val("y", out_data, e);
    y    = out_data;
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk_val("hold_data", out_data, held);
      chk_val("hold_valid", 68'(out_valid), 68'd1);
      chk_val("hold_busy", 68'(in_ready), 68'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_val("drop_valid", 68'(out_valid), 68'd0);
  endtask

  task automatic send(input logic signed [17:0] x, input int bp, output logic signed [67:0] y);
    logic signed [67:0] e;
    wait_ready();
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    hist.push_back(x);
    e = gold();
    chk_val("busy", 68'(in_ready), 68'd0);
    wait_out(e, bp, y);
  endtask

  initial begin
    logic signed [67:0] y, e;
    logic signed [17:0] x;
    logic [63:0]        r;
    int                 k;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    chk_val("rst_in_ready", 68'(in_ready), 68'd0);
    chk_val("rst_mac_clear", 68'(mac_clear), 68'd1);
    chk_val("rst_out_valid", 68'(out_valid), 68'd0);
    chk_val("rst_out_data", out_data, 68'd0);
    chk_val("rst_mac_a", 68'(mac_a), 68'd0);
    chk_val("rst_mac_b", 68'(mac_b), 68'd0);
    reset = 1'b0;
    init_wait("por");

    // Impulse response with h[k] = k+1.
    for (int i = 0; i < NTAPS; i++) wr_coef(i, 36'(i + 1));
    for (int i = 0; i <= NTAPS; i++) begin
      send((i == 0) ? 18'sd1 : 18'sd0, 0, y);
      chk_val("impulse", y, (i < NTAPS) ? 68'(i + 1) : 68'd0);
    end

    // Most negative sample times most negative coefficient, accumulated.
    for (int i = 0; i < NTAPS; i++) wr_coef(i, 36'sh8_0000_0000);
    for (int i = 0; i < NTAPS; i++) begin
      send(18'sh20000, 0, y);
      if (i == 0) chk_val("extreme_first", y, 68'd1 << 52);
      if (i == NTAPS - 1) chk_val("extreme_last", y, 68'd1 << 58);
    end

    // Backpressure with a second sample offered while the output is stalled.
    wait_ready();
    in_valid = 1'b1;
    in_data  = 18'sd5;
    tick();
    hist.push_back(18'sd5);
    e = gold();
    in_data = -18'sd7;
    chk_val("bp_busy", 68'(in_ready), 68'd0);
    wait_out(e, 10, y);
    chk_val("bp_ready_after", 68'(in_ready), 68'd1);
    tick();
    in_valid = 1'b0;
    chk_val("bp_accepted", 68'(in_ready), 68'd0);
    hist.push_back(-18'sd7);
    e = gold();
    wait_out(e, 0, y);

    // Reset in the middle of RUN, then an impulse must show no residue.
    rand_coefs();
    wait_ready();
    in_valid = 1'b1;
    in_data  = 18'sd12345;
    tick();
    in_valid = 1'b0;
    repeat (21) tick();
    reset = 1'b1;
    tick();
    chk_val("mid_out_valid", 68'(out_valid), 68'd0);
    chk_val("mid_in_ready", 68'(in_ready), 68'd0);
    chk_val("mid_mac_clear", 68'(mac_clear), 68'd1);
    chk_val("mid_mac_a", 68'(mac_a), 68'd0);
    reset = 1'b0;
    hist.delete();
    init_wait("mid");
    for (int i = 0; i < NTAPS; i++) begin
      send((i == 0) ? 18'sd1 : 18'sd0, 0, y);
      e = coef_m[i];
      chk_val("post_reset_imp", y, e);
    end

    // Signed ramp across pointer wrap with random coefficients and random stalls.
    rand_coefs();
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        for (int j = 0; j < 4; j++) begin
          k = int'($urandom_range(0, NTAPS - 1));
          r = {$urandom(), $urandom()};
          wr_coef(k, r[35:0]);
        end
      end
      x = 18'(i * 1237 - 120000);
      send(x, int'($urandom_range(0, 2)), y);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Control and operand-feed stage that sits directly upstream of the FIR_MAC18x36 multiply-accumulate unit.
- Holds the sample delay line and the coefficient store.
- For each accepted input sample it clears the MAC, streams NTAPS operand pairs (sample, coefficient), then drains the MAC pipeline.
- It captures the 68-bit MAC result and presents it on a valid/ready output.

Parameters:
- NTAPS, 64: number of filter taps; must be a power of two, at least 4.
- MAC_LAT, 4: cycles from an operand pair being presented on mac_a/mac_b to its contribution being visible on mac_out.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  18  signed input sample
- coef_we  in  1  coefficient write enable
- coef_addr  in  log2(NTAPS)  coefficient index k
- coef_data  in  36  signed coefficient h[k]
- mac_clear  out  1  drives the MAC reset
- mac_a  out  18  signed sample operand (registered)
- mac_b  out  36  signed coefficient operand (registered)
- mac_out  in  68  MAC result
- out_valid  out  1  filtered output valid
- out_ready  in  1  downstream accepts output
- out_data  out  68  signed filtered output y[n]

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset values: state=INIT, mac_clear=1, mac_a=0, mac_b=0, out_valid=0, out_data=0, in_ready=0, wr_ptr=0, init counter=0. Coefficient store is not reset.
- INIT:
  - writes 0 to delay-line entry init_cnt each cycle, for NTAPS cycles; mac_clear=1.
  - then goes to IDLE.
- IDLE:
  - in_ready=1, mac_clear=0, operands 0.
  - On in_valid: delay[wr_ptr] <= in_data, base <= wr_ptr, wr_ptr <= wr_ptr+1 (mod NTAPS); go to CLEAR.
- CLEAR (1 cycle): mac_clear=1, operands 0; tap counter k <= 0; go to RUN.
- RUN (NTAPS cycles):
  - during cycle C+1+k, mac_a = delay[(base-k) mod NTAPS] and mac_b = coef[k]; operands are registered, with reads issued one cycle ahead.
  - after k = NTAPS-1 presented, go to DRAIN.
- DRAIN (MAC_LAT cycles): operands forced to 0.
  - On the final DRAIN edge, out_data <= mac_out and out_valid <= 1; go to OUTPUT.
- OUTPUT:
  - out_data held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid <= 0; go to IDLE.
- Operand rule: mac_a and mac_b are 0 in every state except RUN, because the MAC accumulates every cycle.
- Latency: sample accepted in cycle I gives out_valid high from cycle I+NTAPS+MAC_LAT+2 (I+70 at defaults).
- Throughput: one sample per NTAPS+MAC_LAT+3 cycles minimum; in_ready=0 outside IDLE.
- Arithmetic: y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], full precision and signed. mac_out is passed through without truncation. Samples before the first post-reset sample are 0.
- Coefficient writes:
  - accepted in every state and visible to reads from the next cycle.
  - A write to index k during RUN affects the current output only if it lands before tap k is read.
- Wrap-around: pointer arithmetic is modulo NTAPS. The (base-k) index wraps naturally in log2(NTAPS) bits.
- Simultaneous events:
  - in_valid while in OUTPUT is ignored, because in_ready=0.
  - out_ready while not out_valid is ignored.
- Reset mid-operation: any state returns to INIT on the next edge. Any pending out_valid is dropped, the delay line is re-zeroed, and coefficients are retained.

Decomposition:
- Package fir_pkg:
  - width constants SAMP_W=18, COEF_W=36, ACC_W=68.
  - state encoding INIT/IDLE/CLEAR/RUN/DRAIN/OUTPUT.
  - default MAC_LAT=4.
- Sub-module fir_delay_line: NTAPS x 18 circular register array with one write port, one registered read port, and the init clear.
- The coefficient store is an inline register array.

Test Plan:
- Reset, then release:
  - in_ready=0 and mac_clear=1 for exactly 64 cycles, then in_ready=1.
  - mac_a/mac_b stay 0 throughout.
- Impulse, with h[k]=k+1 and inputs 1,0,0,...:
  - outputs are 1,2,3,...,64, then 0.
  - each out_valid rises exactly 70 cycles after acceptance.
- Signed extremes, with all h=-2^35 and 64 samples of -2^17:
  - the 64th output is 2^58 (0x0400_0000_0000_0000, 68 bits).
  - the 1st output is 2^52.
- Backpressure, out_ready held low for 10 cycles:
  - out_data is stable and in_ready=0.
  - a sample offered meanwhile is accepted only in the cycle after the out_ready handshake.
- Reset asserted mid-RUN (tap 20) after non-zero history:
  - out_valid=0 and INIT follows.
  - the next impulse yields exactly h[0..63], with no residue.
- 200-sample signed ramp with random coefficients, run against FIR_MAC18x36 and a golden model:
  - all outputs match across the delay-line pointer wrap.
  - a coefficient rewrite in IDLE takes effect on the next sample.
